// File: rtl/commit_round_scheduler.sv
// rtl/commit_round_scheduler.sv - sequences seed fetch, commitment and drain over T_ROUNDS repetitions
// Capture buffer decouples draining of round t from fetch/commit of round t+1.
module commit_round_scheduler #(
  parameter int          T_ROUNDS = 8,
  parameter logic [7:0]  J_DOMAIN = 8'd0
) (
  input  logic          clk_i,
  input  logic          reset_ni,
  input  logic          start_i,
  output logic          busy_o,
  output logic          done_o,
  output logic          seed_req_o,
  output logic [7:0]    seed_t_o,
  input  logic          seed_ack_i,
  input  logic [2047:0] seed_in_i,
  input  logic [511:0]  aux_in_i,
  output logic          com_start_o,
  input  logic          com_end_i,
  output logic [7:0]    com_t_o,
  output logic [7:0]    com_j_o,
  output logic [2047:0] com_seed_o,
  output logic [511:0]  com_aux_o,
  input  logic [4095:0] com_c_i,
  output logic          c_valid_o,
  input  logic          c_ready_i,
  output logic [255:0]  c_data_o,
  output logic [7:0]    c_t_o,
  output logic [3:0]    c_idx_o,
  output logic          c_last_o
);

  localparam logic [7:0] LAST_ROUND = 8'(T_ROUNDS - 1);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    FETCH   = 3'd1,
    COMMIT  = 3'd2,
    RELEASE = 3'd3,
    FINISH  = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [7:0]      round_q, round_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic [2047:0]   seed_q, seed_d;
  logic [511:0]    aux_q, aux_d;
  logic [4095:0]   buf_q, buf_d;
  logic [7:0]      buf_t_q, buf_t_d;
  logic            full_q, full_d;
  logic [3:0]      idx_q, idx_d;
  logic            capture;
  logic            fire;

  always_ff @(posedge clk_i or negedge reset_ni) begin
    if (!reset_ni) begin
      state_q <= IDLE;
      round_q <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      seed_q  <= '0;
      aux_q   <= '0;
      buf_q   <= '0;
      buf_t_q <= '0;
      full_q  <= 1'b0;
      idx_q   <= '0;
    end else begin
      state_q <= state_d;
      round_q <= round_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      seed_q  <= seed_d;
      aux_q   <= aux_d;
      buf_q   <= buf_d;
      buf_t_q <= buf_t_d;
      full_q  <= full_d;
      idx_q   <= idx_d;
    end
  end

  always_comb begin
    state_d = state_q;
    round_d = round_q;
    busy_d  = busy_q;
    done_d  = 1'b0;
    seed_d  = seed_q;
    aux_d   = aux_q;
    capture = 1'b0;
    case (state_q)
      IDLE: begin
        if (start_i) begin
          round_d = '0;
          busy_d  = 1'b1;
          state_d = FETCH;
        end
      end
      FETCH: begin
        if (seed_ack_i) begin
          seed_d  = seed_in_i;
          aux_d   = aux_in_i;
          state_d = COMMIT;
        end
      end
      COMMIT: begin
        // A full buffer back-pressures the commitment unit, which keeps C stable.
        if (com_end_i && !full_q) begin
          capture = 1'b1;
          state_d = RELEASE;
        end
      end
      RELEASE: begin
        if (!com_end_i) begin
          if (round_q == LAST_ROUND) begin
            state_d = FINISH;
          end else begin
            round_d = round_q + 8'd1;
            state_d = FETCH;
          end
        end
      end
      FINISH: begin
        if (!full_q) begin
          done_d  = 1'b1;
          busy_d  = 1'b0;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    buf_d   = buf_q;
    buf_t_d = buf_t_q;
    full_d  = full_q;
    idx_d   = idx_q;
    fire    = full_q && c_ready_i;
    if (capture) begin
      buf_d   = com_c_i;
      buf_t_d = round_q;
      full_d  = 1'b1;
    end else if (fire) begin
      if (idx_q == 4'd15) begin
        full_d = 1'b0;
        idx_d  = '0;
      end else begin
        idx_d = idx_q + 4'd1;
      end
    end
  end

  assign busy_o      = busy_q;
  assign done_o      = done_q;
  assign seed_req_o  = (state_q == FETCH);
  assign seed_t_o    = round_q;
  assign com_start_o = (state_q == COMMIT);
  assign com_t_o     = round_q;
  assign com_j_o     = J_DOMAIN;
  assign com_seed_o  = seed_q;
  assign com_aux_o   = aux_q;
  assign c_valid_o   = full_q;
  // Word 0 sits in the top slice, so slice offset is (15-idx)*256.
  assign c_data_o    = buf_q[{~idx_q, 8'h00} +: 256];
  assign c_t_o       = buf_t_q;
  assign c_idx_o     = idx_q;
  assign c_last_o    = full_q && (idx_q == 4'd15) && (buf_t_q == LAST_ROUND);

endmodule

// File: tb/tb_commit_round_scheduler.sv
// tb/tb_commit_round_scheduler.sv - directed bench for commit_round_scheduler with seed/commit/sink models
module tb_commit_round_scheduler;

  localparam int T = 2;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start;
  logic          busy, done, seed_req;
  logic [7:0]    seed_t;
  logic          seed_ack;
  logic [2047:0] seed_in;
  logic [511:0]  aux_in;
  logic          com_start, com_end;
  logic [7:0]    com_t, com_j;
  logic [2047:0] com_seed;
  logic [511:0]  com_aux;
  logic [4095:0] com_c;
  logic          c_valid, c_ready;
  logic [255:0]  c_data;
  logic [7:0]    c_t;
  logic [3:0]    c_idx;
  logic          c_last;

  always #5 clk = ~clk;

  commit_round_scheduler #(.T_ROUNDS(T), .J_DOMAIN(8'd0)) dut (
    .clk_i(clk), .reset_ni(reset_n), .start_i(start), .busy_o(busy), .done_o(done),
    .seed_req_o(seed_req), .seed_t_o(seed_t), .seed_ack_i(seed_ack), .seed_in_i(seed_in),
    .aux_in_i(aux_in), .com_start_o(com_start), .com_end_i(com_end), .com_t_o(com_t),
    .com_j_o(com_j), .com_seed_o(com_seed), .com_aux_o(com_aux), .com_c_i(com_c),
    .c_valid_o(c_valid), .c_ready_i(c_ready), .c_data_o(c_data), .c_t_o(c_t),
    .c_idx_o(c_idx), .c_last_o(c_last)
  );

  int tests = 0;
  int fails = 0;
  int run_id = 0;
  int ready_mode = 0;
  int end_hold = 0;
  int req_cnt = 0;
  int exp_word = 0;
  int done_cnt = 0;
  logic [2047:0] last_seed = '0;
  logic [511:0]  last_aux = '0;

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [255:0] cword(input int run, input int t, input int j);
    logic [31:0] tag;
    tag = {8'(run), 8'(t), 8'(j), 8'h5A};
    return {8{tag}};
  endfunction

  function automatic logic [4095:0] cvec(input int run, input int t);
    logic [4095:0] v;
    v = '0;
    for (int j = 0; j < 16; j++) v[(15 - j) * 256 +: 256] = cword(run, t, j);
    return v;
  endfunction

  // Seed store, commitment unit and sink models, evaluated once per cycle.
  initial begin
    int sp, sc, cp, cc, hc;
    sp = 0; sc = 0; cp = 0; cc = 0; hc = 0;
    seed_ack = 1'b0; com_end = 1'b0; com_c = '0; seed_in = '0; aux_in = '0; c_ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (!reset_n) begin
        sp = 0; cp = 0; seed_ack = 1'b0; com_end = 1'b0;
      end else begin
        case (sp)
          0: if (seed_req) begin check("seed_t", seed_t, req_cnt); sc = 0; sp = 1; end
          1: begin
            sc++;
            if (sc == 2) begin
              seed_in = {64{8'(run_id), 8'(req_cnt), 16'hBEEF}};
              aux_in  = {16{8'(run_id), 8'(req_cnt), 16'hA0A0}};
              last_seed = seed_in; last_aux = aux_in;
              req_cnt++;
              seed_ack = 1'b1;
              sp = 2;
            end
          end
          default: begin seed_ack = 1'b0; sp = 0; end
        endcase
        case (cp)
          0: if (com_start) begin
            check("com_seed", com_seed == last_seed, 1);
            check("com_aux", com_aux == last_aux, 1);
            check("com_t", com_t, req_cnt - 1);
            cc = 0; cp = 1;
          end
          1: begin
            cc++;
            if (cc == 20) begin com_c = cvec(run_id, req_cnt - 1); com_end = 1'b1; cp = 2; end
          end
          2: if (!com_start) begin
            if (end_hold == 0) begin com_end = 1'b0; cp = 0; end
            else begin hc = 1; cp = 3; end
          end
          default: if (hc == end_hold) begin com_end = 1'b0; cp = 0; end else hc++;
        endcase
      end
      case (ready_mode)
        0: c_ready = 1'b1;
        1: c_ready = 1'b0;
        default: c_ready = ~c_ready;
      endcase
    end
  end

  // Output monitor: word order/content, stall stability, done pulses.
  initial begin
    logic stall_prev;
    logic [255:0] pd;
    logic [7:0] pt;
    logic [3:0] pi;
    stall_prev = 1'b0; pd = '0; pt = '0; pi = '0;
    forever begin
      @(negedge clk);
      if (!reset_n) begin
        stall_prev = 1'b0;
      end else begin
        if (done) done_cnt++;
        if (stall_prev) begin
          check("stall_valid", c_valid, 1);
          check("stall_data", c_data, pd);
          check("stall_t", c_t, pt);
          check("stall_idx", c_idx, pi);
        end
        if (c_valid && c_ready) begin
          check("extra_word", exp_word < 16 * T, 1);
          check("c_data", c_data, cword(run_id, exp_word / 16, exp_word % 16));
          check("c_t", c_t, exp_word / 16);
          check("c_idx", c_idx, exp_word % 16);
          check("c_last", c_last, exp_word == 16 * T - 1);
          exp_word++;
        end
        stall_prev = c_valid && !c_ready;
        pd = c_data; pt = c_t; pi = c_idx;
      end
    end
  end

  task automatic tick();
    @(posedge clk); #2;
  endtask

  task automatic start_run(input int id);
    run_id = id; req_cnt = 0; exp_word = 0;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int budget);
    int n, k;
    n = done_cnt; k = 0;
    while (done_cnt == n && k < budget) begin tick(); k++; end
    check(tag, done_cnt != n, 1);
    tick();
  endtask

  initial begin
    int d0, k;
    logic [2047:0] saved;
    reset_n = 1'b0; start = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_seed_req", seed_req, 0);
    check("rst_com_start", com_start, 0);
    check("rst_c_valid", c_valid, 0);
    check("rst_c_data", c_data, 0);
    check("rst_c_last", c_last, 0);
    check("rst_seed_t", seed_t, 0);
    check("rst_c_idx", c_idx, 0);
    check("rst_com_j", com_j, 0);
    reset_n = 1'b1;
    tick();

    // Basic two-round run at full throughput
    ready_mode = 0; end_hold = 0; d0 = done_cnt;
    start_run(1);
    wait_done("t1_done_timeout", 1000);
    check("t1_words", exp_word, 32);
    check("t1_done_cnt", done_cnt - d0, 1);
    check("t1_busy", busy, 0);
    check("t1_done_low", done, 0);

    // Sink stalled: round 1 completion must wait for the buffer
    ready_mode = 1; d0 = done_cnt;
    start_run(2);
    k = 0;
    while (!(com_end && req_cnt == 2) && k < 500) begin tick(); k++; end
    check("t2_com_end_timeout", com_end && req_cnt == 2, 1);
    repeat (10) tick();
    check("t2_com_start_held", com_start, 1);
    check("t2_c_valid", c_valid, 1);
    check("t2_c_t", c_t, 0);
    check("t2_c_idx", c_idx, 0);
    check("t2_no_words", exp_word, 0);
    ready_mode = 0;
    wait_done("t2_done_timeout", 1000);
    check("t2_words", exp_word, 32);
    check("t2_done_cnt", done_cnt - d0, 1);

    // Sink toggling every cycle
    ready_mode = 2; d0 = done_cnt;
    start_run(3);
    wait_done("t3_done_timeout", 2000);
    check("t3_words", exp_word, 32);
    check("t3_done_cnt", done_cnt - d0, 1);

    // com_end held 5 cycles past com_start falling
    ready_mode = 0; end_hold = 5; d0 = done_cnt;
    start_run(4);
    k = 0;
    while (!com_start && k < 200) begin tick(); k++; end
    k = 0;
    while (com_start && k < 200) begin tick(); k++; end
    k = 0;
    while (!seed_req && k < 50) begin tick(); k++; end
    check("t4_release_cycles", k, 6);
    wait_done("t4_done_timeout", 1000);
    check("t4_words", exp_word, 32);
    end_hold = 0;

    // Spurious seed_ack in IDLE and start while busy
    saved = last_seed;
    seed_in = '1; aux_in = '1; seed_ack = 1'b1;
    tick();
    seed_ack = 1'b0;
    tick();
    check("t5_idle_seed_req", seed_req, 0);
    check("t5_idle_busy", busy, 0);
    check("t5_seed_kept", com_seed == saved, 1);
    d0 = done_cnt;
    start_run(5);
    repeat (5) tick();
    start = 1'b1;
    tick();
    start = 1'b0;
    wait_done("t5_done_timeout", 1000);
    check("t5_words", exp_word, 32);
    check("t5_done_cnt", done_cnt - d0, 1);
    check("t5_req_cnt", req_cnt, 2);
    repeat (3) tick();
    check("t5_busy_after", busy, 0);
    check("t5_no_restart", seed_req, 0);

    // Reset in the middle of round 1 commit
    start_run(6);
    k = 0;
    while (!(com_start && req_cnt == 2) && k < 500) begin tick(); k++; end
    check("t6_reach_commit", com_start && req_cnt == 2, 1);
    repeat (3) tick();
    d0 = done_cnt;
    reset_n = 1'b0;
    #1;
    check("t6_busy", busy, 0);
    check("t6_seed_req", seed_req, 0);
    check("t6_com_start", com_start, 0);
    check("t6_c_valid", c_valid, 0);
    check("t6_c_data", c_data, 0);
    check("t6_com_t", com_t, 0);
    check("t6_com_seed", com_seed == '0, 1);
    check("t6_done", done, 0);
    repeat (3) tick();
    reset_n = 1'b1;
    repeat (5) tick();
    check("t6_no_done", done_cnt - d0, 0);
    check("t6_idle_busy", busy, 0);
    start_run(7);
    wait_done("t6_done_timeout", 1000);
    check("t6_words", exp_word, 32);
    check("t6_done_cnt", done_cnt - d0, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
